pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 106 ++++++++++
 tb/tb_pc_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter sequencing controller: fetch handshake with timeout, decode,
// branch resolution, retire counting, and absorbing HALT / ERROR states.
module pc_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        imem_ready,
    input  logic [1:0]  instr_class,
    input  logic        alu_valid,
    input  logic        alu_branch_result,
    input  logic        stall,
    output logic        imem_req,
    output logic        ir_load,
    output logic [1:0]  pc_inc,
    output logic [15:0] retired,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_BRANCH = 3'd2,
        S_HALT   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;
    logic        req, ld;
    logic [1:0]  pc_sel;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        req     = 1'b0;
        ld      = 1'b0;
        pc_sel  = 2'b00;
        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (imem_ready) begin
                    ld      = 1'b1;
                    wait_d  = 4'd0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    case (instr_class)
                        2'b00: begin pc_sel = 2'b01; retire = 1'b1; state_d = S_FETCH; end
                        2'b10: begin pc_sel = 2'b11; retire = 1'b1; state_d = S_FETCH; end
                        2'b01: state_d = S_BRANCH;
                        default: begin retire = 1'b1; state_d = S_HALT; end
                    endcase
                end
            end
            S_BRANCH: begin
                // stall wins; the ALU keeps alu_valid up until we take it
                if (alu_valid && !stall) begin
                    pc_sel  = alu_branch_result ? 2'b10 : 2'b01;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    assign retired_d = retired_q + {15'd0, retire};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are gated by clr so they drop the moment reset asserts,
    // even though the reset state itself is FETCH.
    assign imem_req  = req & clr;
    assign ir_load   = ld & clr;
    assign pc_inc    = clr ? pc_sel : 2'b00;
    assign retired   = retired_q;
    assign halted    = (state_q == S_HALT);
    assign fetch_err = (state_q == S_ERROR);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus queues hand-computed expectations,
// a monitor pops and compares them mid-cycle or on asynchronous check events.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        imem_ready;
    logic [1:0]  instr_class;
    logic        alu_valid;
    logic        alu_branch_result;
    logic        stall;
    logic        imem_req;
    logic        ir_load;
    logic [1:0]  pc_inc;
    logic [15:0] retired;
    logic        halted;
    logic        fetch_err;

    pc_ctrl #(.TIMEOUT(15)) dut (
        .clk               (clk),
        .clr               (clr),
        .imem_ready        (imem_ready),
        .instr_class       (instr_class),
        .alu_valid         (alu_valid),
        .alu_branch_result (alu_branch_result),
        .stall             (stall),
        .imem_req          (imem_req),
        .ir_load           (ir_load),
        .pc_inc            (pc_inc),
        .retired           (retired),
        .halted            (halted),
        .fetch_err         (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    event ev_async;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [21:0] ex(input logic req, input logic ld, input logic [1:0] pc,
                                       input logic hlt, input logic err, input logic [15:0] ret);
        return {req, ld, pc, hlt, err, ret};
    endfunction

    // Monitor: every negedge (cycle records) or on demand (asynchronous checks)
    initial begin
        exp_t        e;
        logic [21:0] act;
        forever begin
            @(negedge clk or ev_async);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {imem_req, ir_load, pc_inc, halted, fetch_err, retired};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: got req=%b ld=%b pc=%b halt=%b err=%b ret=%h, want req=%b ld=%b pc=%b halt=%b err=%b ret=%h",
                             e.name, act[21], act[20], act[19:18], act[17], act[16], act[15:0],
                             e.v[21], e.v[20], e.v[19:18], e.v[17], e.v[16], e.v[15:0]);
                end
            end
        end
    end

    // One clock cycle: entered and left at posedge+1
    task automatic cyc(input logic rdy, input logic [1:0] cls, input logic av, input logic ar,
                       input logic st, input string name, input logic [21:0] v);
        exp_t e;
        imem_ready = rdy; instr_class = cls; alu_valid = av; alu_branch_result = ar; stall = st;
        e.name = name; e.v = v;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic expect_now(input string name, input logic [21:0] v);
        exp_t e;
        e.name = name; e.v = v;
        q.push_back(e);
        -> ev_async;
        #0;
    endtask

    initial begin
        clr = 1'b0; imem_ready = 1'b0; instr_class = 2'b00;
        alu_valid = 1'b0; alu_branch_result = 1'b0; stall = 1'b0;
        #3 expect_now("reset", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        @(posedge clk); #1 clr = 1'b1;

        // three sequential instructions back to back
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b00, 0, 0, 0, "seq_fetch",  ex(1, 1, 2'b00, 0, 0, 16'(i)));
            cyc(1, 2'b00, 0, 0, 0, "seq_decode", ex(0, 0, 2'b01, 0, 0, 16'(i)));
        end

        // taken branch, ALU result two cycles late; alu_valid in FETCH is ignored
        cyc(1, 2'b01, 1, 1, 0, "br_fetch",  ex(1, 1, 2'b00, 0, 0, 16'd3));
        cyc(1, 2'b01, 0, 0, 0, "br_decode", ex(0, 0, 2'b00, 0, 0, 16'd3));
        cyc(0, 2'b00, 0, 0, 0, "br_wait1",  ex(0, 0, 2'b00, 0, 0, 16'd3));
        cyc(0, 2'b00, 0, 0, 0, "br_wait2",  ex(0, 0, 2'b00, 0, 0, 16'd3));
        cyc(0, 2'b00, 1, 1, 0, "br_taken",  ex(0, 0, 2'b10, 0, 0, 16'd3));

        // not-taken branch held off by stall for three cycles
        cyc(1, 2'b01, 0, 0, 0, "br2_fetch",  ex(1, 1, 2'b00, 0, 0, 16'd4));
        cyc(1, 2'b01, 0, 0, 0, "br2_decode", ex(0, 0, 2'b00, 0, 0, 16'd4));
        for (int i = 0; i < 3; i++)
            cyc(0, 2'b00, 1, 0, 1, "br2_stall", ex(0, 0, 2'b00, 0, 0, 16'd4));
        cyc(0, 2'b00, 1, 0, 0, "br2_nottaken", ex(0, 0, 2'b01, 0, 0, 16'd4));

        // jump stalled in DECODE
        cyc(1, 2'b10, 0, 0, 0, "jmp_fetch", ex(1, 1, 2'b00, 0, 0, 16'd5));
        cyc(1, 2'b10, 0, 0, 1, "jmp_stall", ex(0, 0, 2'b00, 0, 0, 16'd5));
        cyc(1, 2'b10, 0, 0, 1, "jmp_stall", ex(0, 0, 2'b00, 0, 0, 16'd5));
        cyc(1, 2'b10, 0, 0, 0, "jmp_decode", ex(0, 0, 2'b11, 0, 0, 16'd5));

        // slow fetch, then a timeout that must count from zero again
        for (int i = 0; i < 3; i++)
            cyc(0, 2'b00, 0, 0, 0, "fetch_wait", ex(1, 0, 2'b00, 0, 0, 16'd6));
        cyc(1, 2'b00, 0, 0, 0, "fetch_late", ex(1, 1, 2'b00, 0, 0, 16'd6));
        cyc(0, 2'b00, 0, 0, 0, "seq2_decode", ex(0, 0, 2'b01, 0, 0, 16'd6));
        for (int i = 0; i < 15; i++)
            cyc(0, 2'b00, 0, 0, 0, "to_fetch", ex(1, 0, 2'b00, 0, 0, 16'd7));
        for (int i = 0; i < 3; i++)
            cyc(1, 2'b11, 1, 1, 0, "to_error", ex(0, 0, 2'b00, 0, 1, 16'd7));
        #2 clr = 1'b0;
        #1 expect_now("err_clr", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        @(posedge clk); #1 clr = 1'b1;

        // retire counter wrap, then halt; counter parked at 0xFFFF during a stall
        cyc(1, 2'b00, 0, 0, 0, "wrap_fetch", ex(1, 1, 2'b00, 0, 0, 16'h0000));
        force dut.retired_q = 16'hFFFF;
        cyc(1, 2'b00, 0, 0, 1, "wrap_stall", ex(0, 0, 2'b00, 0, 0, 16'hFFFF));
        release dut.retired_q;
        cyc(1, 2'b00, 0, 0, 0, "wrap_decode", ex(0, 0, 2'b01, 0, 0, 16'hFFFF));
        cyc(1, 2'b11, 0, 0, 0, "wrap_fetch2", ex(1, 1, 2'b00, 0, 0, 16'h0000));
        cyc(1, 2'b11, 0, 0, 0, "halt_decode", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        cyc(1, 2'b00, 1, 1, 0, "halted", ex(0, 0, 2'b00, 1, 0, 16'h0001));
        cyc(1, 2'b00, 1, 1, 0, "halted", ex(0, 0, 2'b00, 1, 0, 16'h0001));
        #2 clr = 1'b0;
        #1 expect_now("halt_clr", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        @(posedge clk); #1 clr = 1'b1;

        // reset asserted between edges while a branch resolves
        cyc(1, 2'b01, 0, 0, 0, "mb_fetch",  ex(1, 1, 2'b00, 0, 0, 16'h0000));
        cyc(1, 2'b01, 0, 0, 0, "mb_decode", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        imem_ready = 1'b0; alu_valid = 1'b1; alu_branch_result = 1'b1; stall = 1'b0;
        #1 expect_now("mb_pre", ex(0, 0, 2'b10, 0, 0, 16'h0000));
        #1 clr = 1'b0;
        #1 expect_now("mb_clr", ex(0, 0, 2'b00, 0, 0, 16'h0000));
        @(posedge clk); #1 clr = 1'b1;
        cyc(1, 2'b00, 1, 1, 0, "mb_resume", ex(1, 1, 2'b00, 0, 0, 16'h0000));
        cyc(1, 2'b00, 0, 0, 0, "mb_seq",    ex(0, 0, 2'b01, 0, 0, 16'h0000));
        cyc(0, 2'b00, 0, 0, 0, "mb_next",   ex(1, 0, 2'b00, 0, 0, 16'h0001));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
